// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/serial_fs_cell.sv
// One-bit full subtractor: a - b - c, producing a difference bit and a borrow out.
module serial_fs_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic difference,
  output logic borrow
);

  assign difference = a ^ b ^ c;
  assign borrow     = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell walks the operands LSB first over WIDTH cycles.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  // One extra bit so the counter can hold WIDTH itself without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             cell_d, cell_b;

  serial_fs_cell u_cell (
    .a          (a_sr[0]),
    .b          (b_sr[0]),
    .c          (borrow),
    .difference (cell_d),
    .borrow     (cell_b)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign ready    = (state == IDLE);
  assign done     = (state == DONE);

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every datapath register, not just the state.
    if (rst) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      cnt        <= '0;
      difference <= '0;
      borrow     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            cnt    <= '0;
            borrow <= 1'b0;
          end
        end
        SHIFT: begin
          a_sr       <= a_sr >> 1;
          b_sr       <= b_sr >> 1;
          difference <= {cell_d, difference[WIDTH-1:1]};
          borrow     <= cell_b;
          cnt        <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_sign, b_sign;

  // The last cell difference becomes the result MSB on the DONE-entry edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sign   <= 1'b0;
      b_sign   <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sign <= a[WIDTH-1];
      b_sign <= b[WIDTH-1];
    end else if (state == SHIFT && last_bit) begin
      overflow <= (a_sign != b_sign) & (cell_d != a_sign);
    end
  end
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH=8 and WIDTH=13 against an arithmetic reference.
module tb_serial_sub_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start13;
  logic [7:0]  a8, b8, diff8;
  logic [12:0] a13, b13, diff13;
  logic        rdy8, rdy13, done8, done13, bor8, bor13;
`ifdef SERIAL_SUB_OVF_EN
  logic        ovf8, ovf13;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q13[$];

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) u8 (
    .clk        (clk),
    .rst        (rst),
    .start      (start8),
    .a          (a8),
    .b          (b8),
    .ready      (rdy8),
    .done       (done8),
    .difference (diff8),
    .borrow     (bor8)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow   (ovf8)
`endif
  );

  serial_sub_ctrl #(.WIDTH(13)) u13 (
    .clk        (clk),
    .rst        (rst),
    .start      (start13),
    .a          (a13),
    .b          (b13),
    .ready      (rdy13),
    .done       (done13),
    .difference (diff13),
    .borrow     (bor13)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow   (ovf13)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: unsigned a - b modulo 2^w, borrow when a < b, signed overflow by range test.
  function automatic exp_t ref_sub(input int w, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint m, ua, ub, sa, sb, r;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    r  = ua - ub;
    if (r < 0) r += m;
    e.diff   = 32'(r);
    e.borrow = (ua < ub);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    r  = sa - sb;
    e.ovf = (r < -(m / 2)) || (r >= m / 2);
    return e;
  endfunction

  // Expected results enter the queues on each accepting edge.
  always @(posedge clk) begin
    if (!rst && start8 && rdy8)   q8.push_back(ref_sub(8, 32'(a8), 32'(b8)));
    if (!rst && start13 && rdy13) q13.push_back(ref_sub(13, 32'(a13), 32'(b13)));
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) check("done8_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        check("diff8", 32'(diff8), e.diff);
        check("borrow8", 32'(bor8), 32'(e.borrow));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf8", 32'(ovf8), 32'(e.ovf));
`endif
      end
    end
    if (done13) begin
      if (q13.size() == 0) check("done13_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q13.pop_front();
        check("diff13", 32'(diff13), e.diff);
        check("borrow13", 32'(bor13), 32'(e.borrow));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf13", 32'(ovf13), 32'(e.ovf));
`endif
      end
    end
  end

  task automatic wait_ready(input int sel);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if ((sel == 0) ? rdy8 : rdy13) return;
    end
    check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Returns at the negedge after the accepting edge.
  task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] b);
    wait_ready(sel);
    if (sel == 0) begin
      a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    end else begin
      a13 = a[12:0]; b13 = b[12:0]; start13 = 1'b1;
    end
    @(negedge clk);
    if (sel == 0) start8 = 1'b0;
    else start13 = 1'b0;
  endtask

  task automatic measure_latency(input int sel, output int lat);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if ((sel == 0) ? done8 : done13) begin
        lat = k;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, n_acc, acc0, acc1, dones;

    rst = 1'b1; start8 = 1'b0; start13 = 1'b0;
    a8 = '0; b8 = '0; a13 = '0; b13 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_ready8", 32'(rdy8), 32'd1);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_diff8", 32'(diff8), 32'd0);
    check("rst_borrow8", 32'(bor8), 32'd0);
    check("rst_ready13", 32'(rdy13), 32'd1);
    check("rst_diff13", 32'(diff13), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf8", 32'(ovf8), 32'd0);
`endif

    issue(0, 32'h05, 32'h03);
    measure_latency(0, lat);
    check("latency8", 32'(lat), 32'd8);
    repeat (3) @(negedge clk);
    check("hold_diff8", 32'(diff8), 32'h02);
    check("hold_borrow8", 32'(bor8), 32'd0);
    check("hold_ready8", 32'(rdy8), 32'd1);

    issue(1, 32'h0000, 32'h1FFF);
    measure_latency(1, lat);
    check("latency13", 32'(lat), 32'd13);

    issue(0, 32'h03, 32'h05);
    issue(0, 32'h00, 32'h00);
    issue(0, 32'h80, 32'h01);
    issue(0, 32'hFF, 32'hFF);
    issue(0, 32'h00, 32'hFF);
    issue(0, 32'h7F, 32'h80);
    issue(1, 32'h1FFF, 32'h0000);
    issue(1, 32'h1000, 32'h0001);
    issue(1, 32'h0FFF, 32'h1FFF);

    // start held high: accepts only at edges 0 and WIDTH+2, one done in the window.
    wait_ready(0);
    a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
    n_acc = 0; acc0 = -1; acc1 = -1; dones = 0;
    for (int e = 0; e < 12; e++) begin
      if (rdy8) begin
        if (n_acc == 0) acc0 = e;
        else if (n_acc == 1) acc1 = e;
        n_acc++;
      end
      @(negedge clk);
      if (done8) dones++;
    end
    start8 = 1'b0;
    check("held_acc0", 32'(acc0), 32'd0);
    check("held_acc1", 32'(acc1), 32'd10);
    check("held_nacc", 32'(n_acc), 32'd2);
    check("held_dones", 32'(dones), 32'd1);

    // Reset in the middle of SHIFT aborts the operation.
    issue(0, 32'h5A, 32'h33);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q8.delete();
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready8", 32'(rdy8), 32'd1);
    check("abort_done8", 32'(done8), 32'd0);
    check("abort_diff8", 32'(diff8), 32'd0);
    check("abort_borrow8", 32'(bor8), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("abort_ovf8", 32'(ovf8), 32'd0);
`endif
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    issue(0, 32'h5A, 32'h33);

    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          issue(0, $urandom & 32'hFF, $urandom & 32'hFF);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          issue(1, $urandom & 32'h1FFF, $urandom & 32'h1FFF);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    join

    repeat (30) @(negedge clk);
    check("drain_q8", 32'(q8.size()), 32'd0);
    check("drain_q13", 32'(q13.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
